// File: rtl/spi_pkt_slave.sv
// spi_pkt_slave: holds the latest RF packet and shifts it out MSB-first on MISO (SPI mode 0); assembles MOSI bytes.
// Latency: SPI pins reach edge detection after SYNC_STAGES+1 clk; MISO moves 1 clk after a detected SCK fall.
// Backpressure: none; a new packet over an unread one overwrites it and sets the sticky overrun flag.
// Ports: clk/rst (async active-high); pkt_in/pkt_rec from the packet register; CS/SCK/MOSI/MISO SPI pins;
//        pkt_pend/pkt_sent packet status; rx_byte/rx_valid received command bytes; overrun sticky error.
module spi_pkt_slave #(
    parameter int PKT_BYTES   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*PKT_BYTES-1:0] pkt_in,
    input  logic                   pkt_rec,
    input  logic                   CS,
    input  logic                   SCK,
    input  logic                   MOSI,
    output logic                   MISO,
    output logic                   pkt_pend,
    output logic                   pkt_sent,
    output logic [7:0]             rx_byte,
    output logic                   rx_valid,
    output logic                   overrun
);
    localparam int PKT_W = 8 * PKT_BYTES;
    localparam int CNT_W = $clog2(PKT_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

    // Synchronizers plus one registered copy for edge detection
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   cs_prev_q, sck_prev_q;
    logic                   cs_s, sck_s, mosi_s;
    logic                   cs_fall, cs_rise, sck_rise, sck_fall;

    state_t             state_q, state_d;
    logic [PKT_W-1:0]   shift_q, shift_d;
    logic [PKT_W-1:0]   hold_q, hold_d;
    logic               pend_q, pend_d;
    logic               snap_pend_q, snap_pend_d;
    logic               fresh_q, fresh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [6:0]         rx_sh_q, rx_sh_d;
    logic [7:0]         rx_byte_q, rx_byte_d;
    logic               rx_valid_q, rx_valid_d;
    logic               pkt_sent_q, pkt_sent_d;
    logic               overrun_q, overrun_d;
    logic               clear_pend;
    logic               pend_snapped;

    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS};
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SCK};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    end

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign cs_fall  = cs_prev_q & ~cs_s;
    assign cs_rise  = ~cs_prev_q & cs_s;
    assign sck_rise = ~sck_prev_q & sck_s;
    assign sck_fall = sck_prev_q & ~sck_s;

    // The held packet counts as already taken by a transfer if it is being snapped
    // right now, or was snapped at CS fall and not replaced by a fresher one since.
    assign pend_snapped = (state_q == IDLE) ? cs_fall : (snap_pend_q & ~fresh_q);

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        pend_d      = pend_q;
        snap_pend_d = snap_pend_q;
        fresh_d     = fresh_q;
        cnt_d       = cnt_q;
        rx_sh_d     = rx_sh_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        pkt_sent_d  = 1'b0;
        overrun_d   = overrun_q;
        clear_pend  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cs_fall) begin
                    shift_d     = pend_q ? hold_q : '0;
                    snap_pend_d = pend_q;
                    fresh_d     = 1'b0;
                    rx_sh_d     = '0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    // Abort: the pending packet stays held for the next read
                    state_d = IDLE;
                    cnt_d   = '0;
                    rx_sh_d = '0;
                end else if (sck_rise) begin
                    rx_sh_d = {rx_sh_q[5:0], mosi_s};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q[2:0] == 3'd7) begin
                        rx_byte_d  = {rx_sh_q, mosi_s};
                        rx_valid_d = 1'b1;
                    end
                    if (cnt_q == CNT_W'(PKT_W - 1)) begin
                        if (snap_pend_q) begin
                            pkt_sent_d = 1'b1;
                            clear_pend = ~fresh_q;
                        end
                        state_d = DRAIN;
                    end
                end else if (sck_fall) begin
                    shift_d = {shift_q[PKT_W-2:0], 1'b0};
                end
            end
            DRAIN: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear_pend) begin
            pend_d = 1'b0;
        end
        // A new packet is always captured and always wins over a same-cycle clear
        if (pkt_rec) begin
            hold_d = pkt_in;
            pend_d = 1'b1;
            if (state_q != IDLE || cs_fall) begin
                fresh_d = 1'b1;
            end
            if (pend_q && !pend_snapped) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync_q   <= '1;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sck_prev_q  <= 1'b0;
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            pend_q      <= 1'b0;
            snap_pend_q <= 1'b0;
            fresh_q     <= 1'b0;
            cnt_q       <= '0;
            rx_sh_q     <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            pkt_sent_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_prev_q   <= cs_s;
            sck_prev_q  <= sck_s;
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            pend_q      <= pend_d;
            snap_pend_q <= snap_pend_d;
            fresh_q     <= fresh_d;
            cnt_q       <= cnt_d;
            rx_sh_q     <= rx_sh_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            pkt_sent_q  <= pkt_sent_d;
            overrun_q   <= overrun_d;
        end
    end

    assign MISO     = (state_q == SHIFT) & shift_q[PKT_W-1];
    assign pkt_pend = pend_q;
    assign pkt_sent = pkt_sent_q;
    assign rx_byte  = rx_byte_q;
    assign rx_valid = rx_valid_q;
    assign overrun  = overrun_q;

endmodule
